// File: rtl/video_pixel_out.sv
// video_pixel_out: pixel output stage behind the video timing controller.
// Buffers a valid/ready pixel stream (sof-tagged) in a FIFO, locks the stream
// to the controller's frame start and pops one pixel per den cycle. Pixel data
// and hsync/vsync/den leave together, two cycles after the timing inputs.
// Optional feature macro: VIDEO_PIXOUT_STATS_EN (saturating underflow counter).
module video_pixel_out #(
  parameter int unsigned       DATA_W       = 24,
  parameter int unsigned       FIFO_AW      = 10,
  parameter logic [DATA_W-1:0] BORDER_COLOR = 24'h000000
) (
  input  logic                pixel_clock,
  input  logic                rst,
  input  logic [DATA_W-1:0]   in_data,
  input  logic                in_sof,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                tim_hsync,
  input  logic                tim_vsync,
  input  logic                tim_den,
  input  logic [13:0]         tim_pixel_x,
  input  logic [13:0]         tim_pixel_y,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_hsync,
  output logic                out_vsync,
  output logic                out_den,
  output logic [FIFO_AW:0]    fifo_level,
  output logic                locked,
  output logic                underflow,
  output logic [15:0]         underflow_count
);

  localparam int unsigned      DEPTH    = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_LVL = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [FIFO_AW:0] LVL_ONE  = {{FIFO_AW{1'b0}}, 1'b1};
  localparam logic [FIFO_AW-1:0] PTR_ONE = {{(FIFO_AW-1){1'b0}}, 1'b1};

  typedef enum logic {
    ST_WAIT_SOF = 1'b0,
    ST_RUN      = 1'b1
  } state_e;

  // FIFO storage; sof is read asynchronously so the head can steer the FSM
  logic [DATA_W-1:0]  data_mem [DEPTH];
  logic               sof_mem  [DEPTH];
  logic [DATA_W-1:0]  rd_data_q;

  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   level_q, level_d;
  state_e             state_q, state_d;

  // Stage 1: aligned with the registered RAM read
  logic s1_den_q, s1_den_d;
  logic s1_hs_q,  s1_hs_d;
  logic s1_vs_q,  s1_vs_d;
  logic s1_show_q, s1_show_d;
  logic s1_uf_q,  s1_uf_d;

  // Stage 2: output register
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic out_den_q, out_den_d;
  logic out_hs_q,  out_hs_d;
  logic out_vs_q,  out_vs_d;
  logic uf_q,      uf_d;

  logic wr_en, pop, show, uf_evt;
  logic head_valid, head_sof, frame_start;

  assign in_ready    = (level_q != FULL_LVL);
  assign wr_en       = in_valid & in_ready;
  assign head_valid  = (level_q != '0);
  assign head_sof    = sof_mem[rd_ptr_q];
  assign frame_start = tim_den && (tim_pixel_x == '0) && (tim_pixel_y == '0);

  // Frame alignment decision: what to pop and whether this den cycle shows it
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    show    = 1'b0;
    uf_evt  = 1'b0;
    case (state_q)
      ST_WAIT_SOF: begin
        if (head_valid && !head_sof) begin
          pop = 1'b1;
        end else if (head_valid && frame_start) begin
          pop     = 1'b1;
          show    = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (tim_den) begin
          if (!head_valid) begin
            uf_evt  = 1'b1;
            state_d = ST_WAIT_SOF;
          end else if (head_sof != frame_start) begin
            // early frame (sof off origin) or late frame (origin without sof)
            state_d = ST_WAIT_SOF;
          end else begin
            pop  = 1'b1;
            show = 1'b1;
          end
        end
      end
      default: state_d = ST_WAIT_SOF;
    endcase
  end

  // Pointer, level and pipeline next-state values
  always_comb begin
    wr_ptr_d = wr_en ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop   ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    level_d  = level_q;
    if (wr_en && !pop) begin
      level_d = level_q + LVL_ONE;
    end else if (!wr_en && pop) begin
      level_d = level_q - LVL_ONE;
    end

    s1_den_d  = tim_den;
    s1_hs_d   = tim_hsync;
    s1_vs_d   = tim_vsync;
    s1_show_d = show;
    s1_uf_d   = uf_evt;

    out_den_d  = s1_den_q;
    out_hs_d   = s1_hs_q;
    out_vs_d   = s1_vs_q;
    uf_d       = s1_uf_q;
    out_data_d = (s1_den_q && s1_show_q) ? rd_data_q : BORDER_COLOR;
  end

  // FIFO memory write and registered head read
  always_ff @(posedge pixel_clock) begin
    if (wr_en) begin
      data_mem[wr_ptr_q] <= in_data;
      sof_mem[wr_ptr_q]  <= in_sof;
    end
    rd_data_q <= data_mem[rd_ptr_q];
  end

  // State, FIFO bookkeeping and output pipeline registers
  always_ff @(posedge pixel_clock) begin
    if (rst) begin
      state_q    <= ST_WAIT_SOF;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      s1_den_q   <= 1'b0;
      s1_hs_q    <= 1'b0;
      s1_vs_q    <= 1'b0;
      s1_show_q  <= 1'b0;
      s1_uf_q    <= 1'b0;
      out_data_q <= BORDER_COLOR;
      out_den_q  <= 1'b0;
      out_hs_q   <= 1'b0;
      out_vs_q   <= 1'b0;
      uf_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      s1_den_q   <= s1_den_d;
      s1_hs_q    <= s1_hs_d;
      s1_vs_q    <= s1_vs_d;
      s1_show_q  <= s1_show_d;
      s1_uf_q    <= s1_uf_d;
      out_data_q <= out_data_d;
      out_den_q  <= out_den_d;
      out_hs_q   <= out_hs_d;
      out_vs_q   <= out_vs_d;
      uf_q       <= uf_d;
    end
  end

  assign out_data   = out_data_q;
  assign out_den    = out_den_q;
  assign out_hsync  = out_hs_q;
  assign out_vsync  = out_vs_q;
  assign underflow  = uf_q;
  assign fifo_level = level_q;
  assign locked     = (state_q == ST_RUN);

`ifdef VIDEO_PIXOUT_STATS_EN
  logic [15:0] uf_cnt_q, uf_cnt_d;

  // Saturating count of underflow pulses
  always_comb begin
    uf_cnt_d = uf_cnt_q;
    if (uf_q && (uf_cnt_q != 16'hFFFF)) begin
      uf_cnt_d = uf_cnt_q + 16'd1;
    end
  end

  // Counter register, cleared only by reset
  always_ff @(posedge pixel_clock) begin
    if (rst) begin
      uf_cnt_q <= '0;
    end else begin
      uf_cnt_q <= uf_cnt_d;
    end
  end

  assign underflow_count = uf_cnt_q;
`else
  assign underflow_count = '0;
`endif

endmodule
